dmem_arbiter: RTL and testbench

//  Shares the single-port data_memory between two requesters: port 0 is the CPU load/store

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/data_memory.sv | 26 ++
 rtl/dmem_arbiter_rr_arb2.sv | 18 +
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared defaults and FSM encodings for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 32;

    // 2'd3 is unused; the FSM decodes it as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory.sv
// Single-port data memory: combinational read gated by MemRead, write on posedge with MemWrite.
module data_memory #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [DATA_W-1:0] data_out
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (MemWrite) begin
            r_mem[addr] <= write_data;
        end
    end

    assign data_out = MemRead ? r_mem[addr] : '0;

endmodule

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the port that did not win last.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_win_c
);

    always_comb begin
        o_win_c = 2'b00;
        case (i_req)
            2'b01:   o_win_c = 2'b01;
            2'b10:   o_win_c = 2'b10;
            2'b11:   o_win_c = i_last ? 2'b01 : 2'b10;
            default: o_win_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing data_memory between the CPU port (0) and the loader port (1).
// One access per grant: gnt (IDLE) -> strobe (ACCESS) -> done (DONE).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last;
    logic              r_owner;
    logic [1:0]        r_done;
    logic [DATA_W-1:0] r_rdata [2];
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_read;
    logic              r_mem_write;

    logic [1:0]        w_req;
    logic [1:0]        w_win;
    logic [1:0]        w_gnt;
    logic              w_load;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_we;

    assign w_req = {r1_req, r0_req};

    rr_arb2 u_rr_arb2 (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_win_c (w_win)
    );

    assign w_sel_addr  = w_win[1] ? r1_addr  : r0_addr;
    assign w_sel_wdata = w_win[1] ? r1_wdata : r0_wdata;
    assign w_sel_we    = w_win[1] ? r1_we    : r0_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grants only leave IDLE; reset suppresses any grant in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 2'b00;
        w_load      = 1'b0;
        case (r_state)
            ST_ACCESS: w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default: begin
                w_state_nxt = ST_IDLE;
                if (|w_win) begin
                    w_gnt       = w_win;
                    w_load      = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
        endcase
        if (rst) begin
            w_gnt       = 2'b00;
            w_load      = 1'b0;
            w_state_nxt = ST_IDLE;
        end
    end

    // Command stage, completion pulse and per-port read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_done      <= 2'b00;
            r_rdata[0]  <= '0;
            r_rdata[1]  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_done      <= 2'b00;
            if (w_load) begin
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
                r_mem_write <= w_sel_we;
                r_mem_read  <= ~w_sel_we;
                r_owner     <= w_win[1];
                r_last      <= w_win[1];
            end
            if (r_state == ST_ACCESS) begin
                r_done[r_owner] <= 1'b1;
                if (r_mem_read) begin
                    r_rdata[r_owner] <= mem_rdata;
                end
            end
        end
    end

    assign r0_gnt    = w_gnt[0];
    assign r1_gnt    = w_gnt[1];
    assign r0_done   = r_done[0];
    assign r1_done   = r_done[1];
    assign r0_rdata  = r_rdata[0];
    assign r1_rdata  = r_rdata[1];
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter in front of data_memory.
module tb_dmem_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
    logic          r0_gnt, r0_done, r1_gnt, r1_done;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_read, mem_write;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    data_memory #(.ADDR_W(AW), .DATA_W(DW)) u_mem (
        .clk(clk), .addr(mem_addr), .write_data(mem_wdata),
        .MemRead(mem_read), .MemWrite(mem_write), .data_out(mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit p, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p) begin
            r1_req = v; r1_we = we; r1_addr = a; r1_wdata = d;
        end else begin
            r0_req = v; r0_we = we; r0_addr = a; r0_wdata = d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Runs one access and reports what was observed; callers decide what is correct.
    task automatic access(input bit p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int waitc, output bit strobe_ok,
                          output bit done_ok, output logic [DW-1:0] rd);
        set_req(p, 1'b1, we, a, d);
        waitc = 0;
        @(negedge clk);
        while (!(p ? r1_gnt : r0_gnt) && waitc < 20) begin
            tick();
            waitc++;
            @(negedge clk);
        end
        tick();
        set_req(p, 1'b0, ~we, ~a, ~d);
        @(negedge clk);
        strobe_ok = (mem_write === we) && (mem_read === ~we) && (mem_addr === a)
                    && (!we || mem_wdata === d) && (r0_done === 1'b0) && (r1_done === 1'b0);
        tick();
        @(negedge clk);
        done_ok = (p ? (r1_done === 1'b1 && r0_done === 1'b0)
                     : (r0_done === 1'b1 && r1_done === 1'b0))
                  && (mem_read === 1'b0) && (mem_write === 1'b0);
        rd = p ? r1_rdata : r0_rdata;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 8'h01, 32'h0);
        @(negedge clk);
        n_vec++; if (r0_gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt: got %b want 0", r0_gnt); end
        tick();
        @(negedge clk);
        n_vec++; if ({mem_read, mem_write} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b want 00", {mem_read, mem_write}); end
        n_vec++; if (mem_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
        n_vec++; if (mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        n_vec++; if ({r0_done, r1_done, r1_gnt} !== 3'b000) begin n_err++; $display("FAIL reset_done: got %b want 000", {r0_done, r1_done, r1_gnt}); end
        n_vec++; if (r0_rdata !== 32'h0 || r1_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h/%h want 0/0", r0_rdata, r1_rdata); end
        tick();
        set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        int w; bit s, dn; logic [DW-1:0] rd;
        access(0, 1'b1, 8'h02, 32'h1111_1234, w, s, dn, rd);
        n_vec++; if (w !== 0) begin n_err++; $display("FAIL wr_gnt_wait: got %0d want 0", w); end
        n_vec++; if (s !== 1'b1) begin n_err++; $display("FAIL wr_strobe: got %b want 1", s); end
        n_vec++; if (dn !== 1'b1) begin n_err++; $display("FAIL wr_done: got %b want 1", dn); end
        access(0, 1'b0, 8'h02, 32'h0, w, s, dn, rd);
        n_vec++; if (s !== 1'b1 || dn !== 1'b1) begin n_err++; $display("FAIL rd_strobe_done: got %b%b want 11", s, dn); end
        n_vec++; if (rd !== 32'h1111_1234) begin n_err++; $display("FAIL rd_data: got %h want 11111234", rd); end
    endtask

    task automatic test_tie();
        do_reset();
        set_req(0, 1'b1, 1'b0, 8'h02, 32'h0);
        set_req(1, 1'b1, 1'b0, 8'h02, 32'h0);
        @(negedge clk);
        n_vec++; if ({r1_gnt, r0_gnt} !== 2'b01) begin n_err++; $display("FAIL tie_first: got %b want 01", {r1_gnt, r0_gnt}); end
        tick();
        r0_req = 1'b0;
        @(negedge clk);
        n_vec++; if (r1_gnt !== 1'b0) begin n_err++; $display("FAIL tie_access_gnt: got %b want 0", r1_gnt); end
        tick();
        @(negedge clk);
        n_vec++; if ({r1_done, r0_done, r1_gnt} !== 3'b010) begin n_err++; $display("FAIL tie_done0: got %b want 010", {r1_done, r0_done, r1_gnt}); end
        tick();
        @(negedge clk);
        n_vec++; if (r1_gnt !== 1'b1) begin n_err++; $display("FAIL tie_second: got %b want 1", r1_gnt); end
        tick();
        r1_req = 1'b0;
        tick();
        @(negedge clk);
        n_vec++; if ({r1_done, r0_done} !== 2'b10 || r1_rdata !== 32'h1111_1234) begin n_err++; $display("FAIL tie_done1: got %b %h want 10 11111234", {r1_done, r0_done}, r1_rdata); end
        tick();
    endtask

    task automatic test_contention();
        int port_q[6];
        int cyc_q[6];
        int n = 0;
        bit both = 1'b0;
        do_reset();
        set_req(0, 1'b1, 1'b0, 8'h02, 32'h0);
        set_req(1, 1'b1, 1'b0, 8'h02, 32'h0);
        for (int c = 0; c < 30 && n < 6; c++) begin
            @(negedge clk);
            if (r0_gnt === 1'b1 && r1_gnt === 1'b1) both = 1'b1;
            if (r0_gnt === 1'b1 || r1_gnt === 1'b1) begin
                port_q[n] = (r1_gnt === 1'b1) ? 1 : 0;
                cyc_q[n]  = c;
                n++;
            end
            tick();
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        tick();
        tick();
        n_vec++; if (n !== 6 || both) begin n_err++; $display("FAIL cont_count: got %0d grants (double=%b) want 6 (0)", n, both); end
        for (int i = 0; i < n; i++) begin
            n_vec++; if (port_q[i] !== (i % 2)) begin n_err++; $display("FAIL cont_order[%0d]: got %0d want %0d", i, port_q[i], i % 2); end
            if (i > 0) begin
                n_vec++; if (cyc_q[i] - cyc_q[i-1] !== 3) begin n_err++; $display("FAIL cont_spacing[%0d]: got %0d want 3", i, cyc_q[i] - cyc_q[i-1]); end
            end
        end
    endtask

    task automatic test_isolation();
        int w; bit s, dn; logic [DW-1:0] rd; logic [DW-1:0] prev;
        prev = r1_rdata;
        access(1, 1'b1, 8'h03, 32'habcd_dcba, w, s, dn, rd);
        n_vec++; if (s !== 1'b1 || dn !== 1'b1 || rd !== prev) begin n_err++; $display("FAIL iso_wr: got %b%b %h want 11 %h", s, dn, rd, prev); end
        access(0, 1'b0, 8'h03, 32'h0, w, s, dn, rd);
        n_vec++; if (rd !== 32'habcd_dcba || dn !== 1'b1) begin n_err++; $display("FAIL iso_rd: got %h done %b want abcddcba done 1", rd, dn); end
        n_vec++; if (r1_rdata !== prev) begin n_err++; $display("FAIL iso_r1_hold: got %h want %h", r1_rdata, prev); end
    endtask

    task automatic test_reset_mid_access();
        set_req(1, 1'b1, 1'b1, 8'h04, 32'hdead_beef);
        @(negedge clk);
        n_vec++; if (r1_gnt !== 1'b1) begin n_err++; $display("FAIL rma_gnt: got %b want 1", r1_gnt); end
        tick();
        set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (mem_write !== 1'b1 || mem_addr !== 8'h04) begin n_err++; $display("FAIL rma_strobe: got %b %h want 1 04", mem_write, mem_addr); end
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 8'h04, 32'h0);
        @(negedge clk);
        n_vec++; if (r1_done !== 1'b0 || mem_write !== 1'b0) begin n_err++; $display("FAIL rma_no_done: got %b%b want 00", r1_done, mem_write); end
        n_vec++; if (r0_gnt !== 1'b1) begin n_err++; $display("FAIL rma_idle: got %b want 1", r0_gnt); end
        n_vec++; if (r0_rdata !== 32'h0) begin n_err++; $display("FAIL rma_rdata_clr: got %h want 0", r0_rdata); end
        tick();
        set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        @(negedge clk);
        n_vec++; if (r0_done !== 1'b1 || r1_done !== 1'b0 || r0_rdata !== 32'hdead_beef) begin n_err++; $display("FAIL rma_commit: got %b%b %h want 10 deadbeef", r0_done, r1_done, r0_rdata); end
        tick();
    endtask

    task automatic test_withdrawn();
        int w; bit s, dn; logic [DW-1:0] rd;
        int bad = 0;
        access(0, 1'b1, 8'h06, 32'h0000_0606, w, s, dn, rd);
        set_req(0, 1'b1, 1'b0, 8'h06, 32'h0);
        @(negedge clk);
        n_vec++; if (r0_gnt !== 1'b1) begin n_err++; $display("FAIL wd_r0_gnt: got %b want 1", r0_gnt); end
        tick();
        set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
        set_req(1, 1'b1, 1'b1, 8'h06, 32'hffff_ffff);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (r1_gnt === 1'b1 || mem_write === 1'b1 || r1_done === 1'b1) bad++;
            tick();
            if (c == 0) set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL wd_no_grant: got %0d bad cycles want 0", bad); end
        access(0, 1'b0, 8'h06, 32'h0, w, s, dn, rd);
        n_vec++; if (rd !== 32'h0000_0606) begin n_err++; $display("FAIL wd_mem_intact: got %h want 00000606", rd); end
    endtask

    initial begin
        #1;
        test_reset();
        test_write_read();
        test_tie();
        test_contention();
        test_isolation();
        test_reset_mid_access();
        test_withdrawn();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
